// File: rtl/rsa_operand_loader.sv
// Operand loader for the mod-exp engine. It assembles n, e and m from a byte stream, range-checks them and starts the engine.
// Latency: the engine start pulse (exp_ready) comes 2 cycles after the last byte is accepted (CHECK, then START).
// Backpressure: in_ready is high only in LOAD/DRAIN and is held low while the engine owns the operands.
// Ports: clk/reset (async, active-low); in_data/in_valid/in_last/in_ready byte stream;
//        m/e/n operands with exp_ready/exp_valid engine handshake; done/busy/err_code host status.
module rsa_operand_loader #(
  parameter int BUS_WIDTH     = 256,
  parameter int COUNTER_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] m,
  output logic [BUS_WIDTH-1:0] e,
  output logic [BUS_WIDTH-1:0] n,
  output logic                 exp_ready,
  input  logic                 exp_valid,
  output logic                 done,
  output logic                 busy,
  output logic [1:0]           err_code
);

  localparam int B = BUS_WIDTH / 8;
  localparam logic [COUNTER_WIDTH-1:0] CNT_B    = COUNTER_WIDTH'(B);
  localparam logic [COUNTER_WIDTH-1:0] CNT_2B   = COUNTER_WIDTH'(2 * B);
  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(3 * B - 1);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FRAME = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;

  typedef enum logic [2:0] {
    S_LOAD,
    S_DRAIN,
    S_CHECK,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic                     accept;
  logic                     cnt_last;
  logic                     range_err;

  assign accept    = in_valid & in_ready;
  assign cnt_last  = (cnt == CNT_LAST);
  // The modulus must be non-zero and the message must already be reduced.
  assign range_err = (n == '0) || (m >= n);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: begin
        if (accept && cnt_last) begin
          state_nxt = in_last ? S_CHECK : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (accept && in_last) begin
          state_nxt = S_LOAD;
        end
      end
      S_CHECK:     state_nxt = range_err ? S_LOAD : S_START;
      S_START:     state_nxt = S_WAIT_ACK;
      // exp_valid may still be high from the previous run. Wait for it to drop first.
      S_WAIT_ACK:  if (!exp_valid) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (exp_valid) state_nxt = S_LOAD;
      default:     state_nxt = S_LOAD;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = 1'b0;
    exp_ready = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      S_LOAD, S_DRAIN: in_ready = reset;
      S_CHECK:         busy = 1'b1;
      S_START: begin
        busy      = 1'b1;
        exp_ready = 1'b1;
      end
      S_WAIT_ACK:      busy = 1'b1;
      S_WAIT_DONE: begin
        busy = 1'b1;
        done = exp_valid;
      end
      default: ;
    endcase
  end

  // Operand shift registers, byte counter and sticky error code
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      n        <= '0;
      e        <= '0;
      m        <= '0;
      err_code <= ERR_NONE;
    end else begin
      if (state == S_LOAD && accept) begin
        if (cnt < CNT_B) begin
          n <= {n[BUS_WIDTH-9:0], in_data};
        end else if (cnt < CNT_2B) begin
          e <= {e[BUS_WIDTH-9:0], in_data};
        end else begin
          m <= {m[BUS_WIDTH-9:0], in_data};
        end

        if (in_last || cnt_last) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + COUNTER_WIDTH'(1);
        end

        // The first byte of a new frame clears the error code. A framing error
        // on that same byte (a one-byte frame) takes precedence.
        if (cnt == '0) begin
          err_code <= ERR_NONE;
        end
        if (in_last != cnt_last) begin
          err_code <= ERR_FRAME;
        end
      end else if (state == S_CHECK && range_err) begin
        err_code <= ERR_RANGE;
      end
    end
  end

endmodule
